// File: rtl/fifo_access_arbiter_if.sv
// fifo_access_arbiter_if
// Groups the signals between the FIFO controller and the logic around it:
// the write requesters, the single reader and the storage array.
//   slave  : controller side (fifo_access_arbiter)
//   master : requester / consumer / storage side
// Signals:
//   wr_req, wr_data_in   per-requester write request and data
//   wr_gnt               one-hot grant back to requesters
//   fifo_wr_en/addr/data write strobe, address and data into storage
//   rd_req               read request from the consumer
//   fifo_rd_en/addr      read strobe and address into storage
//   full, empty, count   occupancy status
//   underflow_err        sticky read-while-empty flag
interface fifo_access_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
);
  logic [NUM_REQ-1:0]        wr_req;
  logic [NUM_REQ*DATA_W-1:0] wr_data_in;
  logic [NUM_REQ-1:0]        wr_gnt;
  logic                      fifo_wr_en;
  logic [ADDR_W-1:0]         fifo_wr_addr;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      rd_req;
  logic                      fifo_rd_en;
  logic [ADDR_W-1:0]         fifo_rd_addr;
  logic                      full;
  logic                      empty;
  logic [ADDR_W:0]           count;
  logic                      underflow_err;

  modport slave (
    input  wr_req, wr_data_in, rd_req,
    output wr_gnt, fifo_wr_en, fifo_wr_addr, fifo_wr_data,
    output fifo_rd_en, fifo_rd_addr, full, empty, count, underflow_err
  );

  modport master (
    output wr_req, wr_data_in, rd_req,
    input  wr_gnt, fifo_wr_en, fifo_wr_addr, fifo_wr_data,
    input  fifo_rd_en, fifo_rd_addr, full, empty, count, underflow_err
  );
endinterface

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter
// Controller for a 2**ADDR_W entry FIFO storage array. Shares the single
// storage write port among NUM_REQ writers with round-robin arbitration,
// serves one reader, and owns the pointers, occupancy count and flags.
// Ports:
//   clk  system clock, all state changes on the rising edge
//   rst  synchronous active-high reset
//   bus  fifo_access_arbiter_if.slave (requests, grants, storage strobes,
//        pointers, status flags)
module fifo_access_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3
) (
  input logic                  clk,
  input logic                  rst,
  fifo_access_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Wide enough to hold rr_last + NUM_REQ before the modulo fold.
  localparam int SUM_W = IDX_W + 2;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    cnt;
  logic [IDX_W-1:0]   rr_last;
  logic               underflow_q;

  logic               full_w;
  logic               empty_w;
  logic               found;
  logic [IDX_W-1:0]   gnt_idx;
  logic [SUM_W-1:0]   cand_sum;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] gnt;
  logic               wr_en;
  logic               rd_en;
  logic [DATA_W-1:0]  wr_data;

  // Flags come only from the registered count, so they never glitch on inputs.
  assign full_w  = (cnt == DEPTH);
  assign empty_w = (cnt == '0);

  // Round-robin search: the requester just after the last winner has the
  // highest priority, wrapping around at NUM_REQ. Since rr_last < NUM_REQ,
  // a single conditional subtract is enough to fold the index back.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = SUM_W'(rr_last) + SUM_W'(k + 1);
      if (cand_sum >= SUM_W'(NUM_REQ)) begin
        cand_sum = cand_sum - SUM_W'(NUM_REQ);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!found && bus.wr_req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A grant is the acceptance of the write; it is withheld when full or in reset.
  always_comb begin
    gnt     = '0;
    wr_data = '0;
    wr_en   = found & ~full_w & ~rst;
    if (wr_en) begin
      gnt[gnt_idx] = 1'b1;
      wr_data      = bus.wr_data_in[gnt_idx*DATA_W +: DATA_W];
    end
  end

  // The read decision also looks only at the current count: a write landing
  // in the same cycle is not bypassed to an empty-FIFO read.
  assign rd_en = bus.rd_req & ~empty_w & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      rr_last     <= IDX_W'(NUM_REQ - 1);
      underflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr  <= wr_ptr + 1'b1;
        rr_last <= gnt_idx;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (bus.rd_req && empty_w) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.wr_gnt        = gnt;
  assign bus.fifo_wr_en    = wr_en;
  assign bus.fifo_wr_addr  = wr_ptr;
  assign bus.fifo_wr_data  = wr_data;
  assign bus.fifo_rd_en    = rd_en;
  assign bus.fifo_rd_addr  = rd_ptr;
  assign bus.full          = full_w;
  assign bus.empty         = empty_w;
  assign bus.count         = cnt;
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb_fifo_access_arbiter
// Self-checking bench for fifo_access_arbiter. Holds a behavioural model
// (data queue, pointer integers, last-winner index) plus a storage array
// written from the DUT's write strobe so that read data order can be checked.
module tb_fifo_access_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 3;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_access_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  fifo_access_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Storage array driven by the controller's write port.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.fifo_wr_en) mem[bus.fifo_wr_addr] <= bus.fifo_wr_data;
  end

  // Reference model state.
  int m_q[$];
  int m_wr_ptr  = 0;
  int m_rd_ptr  = 0;
  int m_rr_last = NUM_REQ - 1;
  bit m_uf      = 1'b0;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations computed from the model before the edge.
  bit          e_rst;
  bit          e_rd_rq;
  int          e_gnt_idx;
  bit          e_rd_en;
  bit          e_full;
  bit          e_empty;
  logic [3:0]  e_gnt;
  logic [7:0]  e_wdata;
  logic [7:0]  exp_rd_data;
  logic [26:0] exp_vec;
  logic [26:0] act_vec;
  logic [7:0]  act_rd_data;

  // Apply inputs, wait to the falling edge, then predict and sample outputs.
  task automatic drive(input bit r, input logic [3:0] rq, input logic [31:0] d, input bit rdq);
    rst            = r;
    bus.wr_req     = rq;
    bus.wr_data_in = d;
    bus.rd_req     = rdq;
    @(negedge clk);
    e_rst     = r;
    e_rd_rq   = rdq;
    e_full    = (m_q.size() == DEPTH);
    e_empty   = (m_q.size() == 0);
    e_gnt_idx = -1;
    if (!r && !e_full) begin
      for (int j = 1; j <= NUM_REQ; j++) begin
        int c;
        c = (m_rr_last + j) % NUM_REQ;
        if (e_gnt_idx < 0 && rq[c]) e_gnt_idx = c;
      end
    end
    e_rd_en     = !r && rdq && !e_empty;
    e_gnt       = (e_gnt_idx >= 0) ? 4'(1 << e_gnt_idx) : 4'b0;
    e_wdata     = (e_gnt_idx >= 0) ? 8'(d >> (8 * e_gnt_idx)) : 8'h00;
    exp_rd_data = e_rd_en ? 8'(m_q[0]) : 8'h00;
    exp_vec = {e_gnt, (e_gnt_idx >= 0), 3'(m_wr_ptr), e_wdata, e_rd_en, 3'(m_rd_ptr),
               4'(m_q.size()), e_full, e_empty, m_uf};
    act_vec = {bus.wr_gnt, bus.fifo_wr_en, bus.fifo_wr_addr, bus.fifo_wr_data, bus.fifo_rd_en,
               bus.fifo_rd_addr, bus.count, bus.full, bus.empty, bus.underflow_err};
    act_rd_data = mem[bus.fifo_rd_addr];
  endtask

  // Advance the model across the rising edge.
  task automatic commit();
    @(posedge clk);
    if (e_rst) begin
      m_q.delete();
      m_wr_ptr  = 0;
      m_rd_ptr  = 0;
      m_rr_last = NUM_REQ - 1;
      m_uf      = 1'b0;
    end else begin
      if (e_rd_en) begin
        m_q.delete(0);
        m_rd_ptr = (m_rd_ptr + 1) % DEPTH;
      end
      if (e_gnt_idx >= 0) begin
        m_q.push_back(int'(e_wdata));
        m_wr_ptr  = (m_wr_ptr + 1) % DEPTH;
        m_rr_last = e_gnt_idx;
      end
      if (e_rd_rq && e_empty) m_uf = 1'b1;
    end
    #1;
  endtask

  task automatic reset_dut();
    drive(1'b1, 4'h0, 32'h0, 1'b0);
    commit();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'hF, 32'hA5A5_A5A5, 1'b1);
      checks++;
      if ({bus.wr_gnt, bus.fifo_wr_en, bus.fifo_rd_en, bus.fifo_wr_data} !== 14'h0) begin
        errors++;
        $display("[TB] FAIL reset_suppress: got gnt=%b wr_en=%b rd_en=%b wdata=%h want all 0",
                 bus.wr_gnt, bus.fifo_wr_en, bus.fifo_rd_en, bus.fifo_wr_data);
      end
      commit();
    end
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    checks++;
    if ({bus.count, bus.empty, bus.full, bus.fifo_wr_addr, bus.fifo_rd_addr, bus.underflow_err}
        !== {4'd0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got count=%0d empty=%b full=%b wa=%0d ra=%0d uf=%b want 0 1 0 0 0 0",
               bus.count, bus.empty, bus.full, bus.fifo_wr_addr, bus.fifo_rd_addr, bus.underflow_err);
    end
    checks++;
    if (act_vec !== exp_vec) begin
      errors++;
      $display("[TB] FAIL reset_model: got %h want %h", act_vec, exp_vec);
    end
    commit();
  endtask

  task automatic test_fill();
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 4'b0001, 32'(8'h10 + i), 1'b0);
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL fill_model[%0d]: got %h want %h", i, act_vec, exp_vec);
      end
      checks++;
      if (i < 8) begin
        if (bus.wr_gnt !== 4'b0001 || bus.fifo_wr_addr !== 3'(i)) begin
          errors++;
          $display("[TB] FAIL fill_grant[%0d]: got gnt=%b addr=%0d want 0001 %0d",
                   i, bus.wr_gnt, bus.fifo_wr_addr, i);
        end
      end else if ({bus.wr_gnt, bus.fifo_wr_addr, bus.full, bus.count} !== {4'b0, 3'd0, 1'b1, 4'd8}) begin
        errors++;
        $display("[TB] FAIL fill_full: got gnt=%b addr=%0d full=%b count=%0d want 0000 0 1 8",
                 bus.wr_gnt, bus.fifo_wr_addr, bus.full, bus.count);
      end
      commit();
    end
  endtask

  task automatic test_round_robin();
    int order_a[6] = '{0, 1, 2, 3, 0, 1};
    int order_b[4] = '{1, 3, 1, 3};
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 4'b1111, $urandom, 1'b1);
      checks++;
      if (bus.wr_gnt !== 4'(1 << order_a[i]) || act_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL rr_all[%0d]: got gnt=%b vec=%h want gnt=%b vec=%h",
                 i, bus.wr_gnt, act_vec, 4'(1 << order_a[i]), exp_vec);
      end
      commit();
    end
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b1010, $urandom, 1'b1);
      checks++;
      if (bus.wr_gnt !== 4'(1 << order_b[i]) || act_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL rr_odd[%0d]: got gnt=%b vec=%h want gnt=%b vec=%h",
                 i, bus.wr_gnt, act_vec, 4'(1 << order_b[i]), exp_vec);
      end
      commit();
    end
  endtask

  task automatic test_full_read_write();
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b0001, 32'(8'h20 + i), 1'b0);
      commit();
    end
    drive(1'b0, 4'b0100, 32'h00C2_0000, 1'b1);
    checks++;
    if ({bus.fifo_rd_en, bus.wr_gnt, bus.count, act_rd_data} !== {1'b1, 4'b0, 4'd8, 8'h20}
        || act_vec !== exp_vec) begin
      errors++;
      $display("[TB] FAIL full_rw_c1: got rd_en=%b gnt=%b count=%0d rdata=%h want 1 0000 8 20",
               bus.fifo_rd_en, bus.wr_gnt, bus.count, act_rd_data);
    end
    commit();
    drive(1'b0, 4'b0100, 32'h00C2_0000, 1'b1);
    checks++;
    if ({bus.fifo_rd_en, bus.wr_gnt, bus.count, bus.fifo_wr_data} !== {1'b1, 4'b0100, 4'd7, 8'hC2}
        || act_vec !== exp_vec) begin
      errors++;
      $display("[TB] FAIL full_rw_c2: got rd_en=%b gnt=%b count=%0d wdata=%h want 1 0100 7 c2",
               bus.fifo_rd_en, bus.wr_gnt, bus.count, bus.fifo_wr_data);
    end
    commit();
    drive(1'b0, 4'b0000, 32'h0, 1'b0);
    checks++;
    if (bus.count !== 4'd7 || bus.full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_rw_c3: got count=%0d full=%b want 7 0", bus.count, bus.full);
    end
    commit();
  endtask

  task automatic test_underflow();
    reset_dut();
    drive(1'b0, 4'b0000, 32'h0, 1'b1);
    checks++;
    if (bus.fifo_rd_en !== 1'b0 || bus.underflow_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL uf_first: got rd_en=%b uf=%b want 0 0", bus.fifo_rd_en, bus.underflow_err);
    end
    commit();
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 4'b0000, 32'h0, 1'b0);
      checks++;
      if (bus.underflow_err !== 1'b1 || act_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL uf_sticky[%0d]: got uf=%b vec=%h want 1 vec=%h",
                 i, bus.underflow_err, act_vec, exp_vec);
      end
      commit();
    end
    reset_dut();
    drive(1'b0, 4'b0001, 32'h0000_005A, 1'b1);
    checks++;
    if ({bus.wr_gnt, bus.fifo_rd_en, bus.underflow_err} !== {4'b0001, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL uf_wr_same: got gnt=%b rd_en=%b uf=%b want 0001 0 0",
               bus.wr_gnt, bus.fifo_rd_en, bus.underflow_err);
    end
    commit();
    drive(1'b0, 4'b0000, 32'h0, 1'b0);
    checks++;
    if ({bus.count, bus.empty, bus.underflow_err} !== {4'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL uf_after: got count=%0d empty=%b uf=%b want 1 0 1",
               bus.count, bus.empty, bus.underflow_err);
    end
    commit();
  endtask

  task automatic test_wrap_reset();
    int writes = 0;
    int reads  = 0;
    int cyc    = 0;
    reset_dut();
    while ((writes < 12 || reads < 12) && cyc < 300) begin
      drive(1'b0, (writes < 12) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom,
            (reads < 12) ? 1'($urandom_range(0, 1)) : 1'b0);
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL wrap_model[%0d]: got %h want %h", cyc, act_vec, exp_vec);
      end
      if (e_rd_en) begin
        checks++;
        if (act_rd_data !== exp_rd_data) begin
          errors++;
          $display("[TB] FAIL wrap_data[%0d]: got %h want %h", cyc, act_rd_data, exp_rd_data);
        end
      end
      if (e_gnt_idx >= 0) writes++;
      if (e_rd_en) reads++;
      commit();
      cyc++;
    end
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    checks++;
    if ({bus.count, bus.empty, bus.fifo_wr_addr, bus.fifo_rd_addr} !== {4'd0, 1'b1, 3'd4, 3'd4}
        || cyc >= 300) begin
      errors++;
      $display("[TB] FAIL wrap_end: got count=%0d empty=%b wa=%0d ra=%0d cycles=%0d want 0 1 4 4 <300",
               bus.count, bus.empty, bus.fifo_wr_addr, bus.fifo_rd_addr, cyc);
    end
    commit();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b0001, $urandom, 1'b0);
      commit();
    end
    drive(1'b1, 4'hF, $urandom, 1'b1);
    checks++;
    if (bus.count !== 4'd5 || bus.wr_gnt !== 4'b0) begin
      errors++;
      $display("[TB] FAIL midrst_cycle: got count=%0d gnt=%b want 5 0000", bus.count, bus.wr_gnt);
    end
    commit();
    drive(1'b0, 4'h0, 32'h0, 1'b0);
    checks++;
    if ({bus.count, bus.empty, bus.fifo_wr_addr, bus.fifo_rd_addr} !== {4'd0, 1'b1, 3'd0, 3'd0}) begin
      errors++;
      $display("[TB] FAIL midrst_after: got count=%0d empty=%b wa=%0d ra=%0d want 0 1 0 0",
               bus.count, bus.empty, bus.fifo_wr_addr, bus.fifo_rd_addr);
    end
    commit();
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit rd;
      r  = ($urandom_range(0, 59) == 0);
      // Alternate read-light and read-heavy phases so both full and empty are visited.
      rd = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(r, 4'($urandom), $urandom, rd);
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL rand_model[%0d]: got %h want %h", i, act_vec, exp_vec);
      end
      if (e_rd_en) begin
        checks++;
        if (act_rd_data !== exp_rd_data) begin
          errors++;
          $display("[TB] FAIL rand_data[%0d]: got %h want %h", i, act_rd_data, exp_rd_data);
        end
      end
      commit();
    end
  endtask

  initial begin
    bus.wr_req     = '0;
    bus.wr_data_in = '0;
    bus.rd_req     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_round_robin();
    test_full_read_write();
    test_underflow();
    test_wrap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
